// File: rtl/mysystem_spi_pkg.sv
// Shared constants for the SPI byte engine: register map, STATUS/CONTROL
// field positions and FSM state encoding.
package mysystem_spi_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned DIV_W     = 8;
   localparam int unsigned BCNT_W    = 3;
   localparam int unsigned DIV_RESET = 3;

   localparam logic [1:0] ADDR_TXDATA  = 2'd0;
   localparam logic [1:0] ADDR_RXDATA  = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_CONTROL = 2'd3;

   localparam int unsigned ST_BUSY     = 0;
   localparam int unsigned ST_RX_VALID = 1;
   localparam int unsigned ST_OVERRUN  = 2;
   localparam int unsigned ST_CSN_ERR  = 3;
   localparam int unsigned ST_ABORT    = 4;

   localparam int unsigned CTRL_DIV_LSB = 0;
   localparam int unsigned CTRL_IE_BIT  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } spi_state_e;

endpackage

// File: rtl/mysystem_spi_shift_core.sv
// Mode-0 MSB-first byte shifter: FSM, half-period and bit counters,
// tx/rx shift registers and registered SCLK/MOSI.
module mysystem_spi_shift_core
   import mysystem_spi_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_c,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [DIV_W-1:0]  div,
   input  logic              csn_in,
   input  logic              miso,
   output logic              busy_c,
   output logic              done_c,
   output logic              abort_c,
   output logic [DATA_W-1:0] rx_byte,
   output logic              sclk,
   output logic              mosi
);

   spi_state_e        state_q, state_d;
   logic [DIV_W-1:0]  hcnt_q, hcnt_d;
   logic [BCNT_W-1:0] bcnt_q, bcnt_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hcnt_q  <= '0;
         bcnt_q  <= '0;
         tx_sh_q <= '0;
         rx_sh_q <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hcnt_q  <= hcnt_d;
         bcnt_q  <= bcnt_d;
         tx_sh_q <= tx_sh_d;
         rx_sh_q <= rx_sh_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
      end
   end

   // Next-state logic; a csn rise in LOW/HIGH takes priority over counting.
   always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      bcnt_d  = bcnt_q;
      tx_sh_d = tx_sh_q;
      rx_sh_d = rx_sh_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_c  = 1'b0;
      abort_c = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               tx_sh_d = tx_data;
               mosi_d  = tx_data[DATA_W-1];
               hcnt_d  = div;
               bcnt_d  = '0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (csn_in) begin
               abort_c = 1'b1;
               sclk_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (hcnt_q == '0) begin
               sclk_d  = 1'b1;
               rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
               hcnt_d  = div;
               state_d = ST_HIGH;
            end else begin
               hcnt_d = hcnt_q - DIV_W'(1);
            end
         end
         ST_HIGH: begin
            if (csn_in) begin
               abort_c = 1'b1;
               sclk_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (hcnt_q == '0) begin
               sclk_d = 1'b0;
               if (bcnt_q == BCNT_W'(DATA_W - 1)) begin
                  state_d = ST_DONE;
               end else begin
                  tx_sh_d = tx_sh_q << 1;
                  mosi_d  = tx_sh_q[DATA_W-2];
                  bcnt_d  = bcnt_q + BCNT_W'(1);
                  hcnt_d  = div;
                  state_d = ST_LOW;
               end
            end else begin
               hcnt_d = hcnt_q - DIV_W'(1);
            end
         end
         ST_DONE: begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_c  = (state_q != ST_IDLE);
   assign rx_byte = rx_sh_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;

endmodule

// File: rtl/mysystem_pio_spi_shift.sv
// Avalon-MM register file around the SPI byte shifter: TXDATA/RXDATA,
// W1C STATUS flags, CONTROL divider/irq-enable and the read mux.
module mysystem_pio_spi_shift
   import mysystem_spi_pkg::*;
#(
   parameter int unsigned DIV_RESET = mysystem_spi_pkg::DIV_RESET
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        spi_csn_in,
   output logic        spi_sclk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        irq
);

   logic              wr_c, tx_wr_c, st_wr_c, ctrl_wr_c;
   logic              start_c, busy_c, done_c, abort_c;
   logic [DATA_W-1:0] rx_byte;
   logic [DATA_W-1:0] rxdata_q, rxdata_d;
   logic              rx_valid_q, rx_valid_d;
   logic              overrun_q, overrun_d;
   logic              csn_err_q, csn_err_d;
   logic              abort_q, abort_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              ie_q, ie_d;
   logic              irq_q, irq_d;
   logic              unused_wdata;

   assign unused_wdata = ^writedata[31:9];

   assign wr_c      = chipselect & ~write_n;
   assign tx_wr_c   = wr_c & (address == ADDR_TXDATA);
   assign st_wr_c   = wr_c & (address == ADDR_STATUS);
   assign ctrl_wr_c = wr_c & (address == ADDR_CONTROL);
   assign start_c   = tx_wr_c & ~busy_c & ~spi_csn_in;

   mysystem_spi_shift_core u_core (
      .clk     (clk),
      .rst_n   (reset_n),
      .start_c (start_c),
      .tx_data (writedata[DATA_W-1:0]),
      .div     (div_q),
      .csn_in  (spi_csn_in),
      .miso    (spi_miso),
      .busy_c  (busy_c),
      .done_c  (done_c),
      .abort_c (abort_c),
      .rx_byte (rx_byte),
      .sclk    (spi_sclk),
      .mosi    (spi_mosi)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxdata_q   <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         csn_err_q  <= 1'b0;
         abort_q    <= 1'b0;
         div_q      <= DIV_W'(DIV_RESET);
         ie_q       <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         rxdata_q   <= rxdata_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         csn_err_q  <= csn_err_d;
         abort_q    <= abort_d;
         div_q      <= div_d;
         ie_q       <= ie_d;
         irq_q      <= irq_d;
      end
   end

   // Event sets dominate a same-cycle W1C; a TXDATA write during DONE is an overrun.
   always_comb begin
      rxdata_d   = done_c ? rx_byte : rxdata_q;
      rx_valid_d = (rx_valid_q & ~(st_wr_c & writedata[ST_RX_VALID])) | done_c;
      overrun_d  = (overrun_q & ~(st_wr_c & writedata[ST_OVERRUN])) | (tx_wr_c & busy_c);
      csn_err_d  = (csn_err_q & ~(st_wr_c & writedata[ST_CSN_ERR]))
                   | (tx_wr_c & ~busy_c & spi_csn_in);
      abort_d    = (abort_q & ~(st_wr_c & writedata[ST_ABORT])) | abort_c;
      div_d      = div_q;
      ie_d       = ie_q;
      if (ctrl_wr_c) begin
         div_d = writedata[CTRL_DIV_LSB +: DIV_W];
         ie_d  = writedata[CTRL_IE_BIT];
      end
      irq_d = rx_valid_d & ie_d;
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         ADDR_TXDATA:  readdata = '0;
         ADDR_RXDATA:  readdata[DATA_W-1:0] = rxdata_q;
         ADDR_STATUS: begin
            readdata[ST_BUSY]     = busy_c;
            readdata[ST_RX_VALID] = rx_valid_q;
            readdata[ST_OVERRUN]  = overrun_q;
            readdata[ST_CSN_ERR]  = csn_err_q;
            readdata[ST_ABORT]    = abort_q;
         end
         ADDR_CONTROL: begin
            readdata[CTRL_DIV_LSB +: DIV_W] = div_q;
            readdata[CTRL_IE_BIT]           = ie_q;
         end
         default: readdata = '0;
      endcase
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_mysystem_pio_spi_shift.sv
// Directed bench for the SPI byte engine: timing, loopback data, W1C
// status flags, overrun, abort, irq and asynchronous reset.
module tb_mysystem_pio_spi_shift;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        spi_csn_in;
   logic        spi_sclk;
   logic        spi_mosi;
   wire         spi_miso;
   logic        irq;

   logic        loop_en;
   logic        miso_fix;
   assign spi_miso = loop_en ? spi_mosi : miso_fix;

   int          total = 0;
   int          bad   = 0;
   int          edges = 0;
   logic [7:0]  mosi_cap = 8'h00;
   int          busy_cycles;
   int          hi_first;
   int          lo_first;

   always #5 clk = ~clk;

   mysystem_pio_spi_shift #(.DIV_RESET(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .spi_csn_in (spi_csn_in),
      .spi_sclk   (spi_sclk),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .irq        (irq)
   );

   // MOSI as seen by the slave on each SCLK rising edge
   always @(posedge spi_sclk) begin
      edges    = edges + 1;
      mosi_cap = {mosi_cap[6:0], spi_mosi};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Count busy cycles from the current negedge; also measure first SCLK runs.
   task automatic wait_idle();
      logic prev;
      int   run;
      busy_cycles = 0;
      hi_first    = 0;
      lo_first    = 0;
      address     = 2'd2;
      #1;
      prev = spi_sclk;
      run  = 0;
      while (readdata[0] && busy_cycles < 2000) begin
         busy_cycles++;
         if (spi_sclk == prev) run++;
         else begin
            if (prev && hi_first == 0) hi_first = run;
            if (!prev && lo_first == 0) lo_first = run;
            run  = 1;
            prev = spi_sclk;
         end
         @(negedge clk);
         #1;
      end
      check("busy_end", 32'(readdata[0]), 32'd0);
   endtask

   logic [31:0] r;

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      spi_csn_in = 1'b1;
      loop_en    = 1'b1;
      miso_fix   = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_sclk", 32'(spi_sclk), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      check("rst_irq",  32'(irq), 32'd0);
      bus_rd(2'd2, r); check("rst_status", r, 32'h0);
      bus_rd(2'd1, r); check("rst_rxdata", r, 32'h0);
      bus_rd(2'd3, r); check("rst_control", r, 32'h3);
      bus_rd(2'd0, r); check("rst_txdata", r, 32'h0);
      reset_n = 1'b1;

      // basic transfer, div=0, loopback
      spi_csn_in = 1'b0;
      bus_wr(2'd3, 32'h000);
      edges = 0;
      bus_wr(2'd0, 32'hA5);
      wait_idle();
      check("basic_busy", busy_cycles, 17);
      check("basic_edges", edges, 8);
      check("basic_mosi", 32'(mosi_cap), 32'hA5);
      check("basic_sclk_idle", 32'(spi_sclk), 32'd0);
      bus_rd(2'd1, r); check("basic_rx", r, 32'hA5);
      bus_rd(2'd2, r); check("basic_status", r, 32'h02);
      bus_wr(2'd2, 32'h1E);
      bus_rd(2'd2, r); check("basic_clr", r, 32'h0);

      // divider: div=3, MISO tied high
      loop_en  = 1'b0;
      miso_fix = 1'b1;
      bus_wr(2'd3, 32'h003);
      edges = 0;
      bus_wr(2'd0, 32'h3C);
      wait_idle();
      check("div_busy", busy_cycles, 65);
      check("div_hi_run", hi_first, 4);
      check("div_lo_run", lo_first, 4);
      check("div_mosi", 32'(mosi_cap), 32'h3C);
      bus_rd(2'd1, r); check("div_rx", r, 32'hFF);
      bus_wr(2'd2, 32'h1E);

      // csn_err: write with chip select deasserted
      spi_csn_in = 1'b1;
      edges = 0;
      bus_wr(2'd0, 32'h55);
      repeat (5) @(negedge clk);
      check("csn_edges", edges, 0);
      bus_rd(2'd2, r); check("csn_status", r, 32'h08);
      bus_wr(2'd2, 32'h08);
      bus_rd(2'd2, r); check("csn_clr", r, 32'h0);
      bus_rd(2'd1, r); check("csn_rx_kept", r, 32'hFF);

      // overrun: second write while busy is dropped
      spi_csn_in = 1'b0;
      loop_en    = 1'b1;
      bus_wr(2'd0, 32'h12);
      bus_wr(2'd0, 32'h34);
      bus_rd(2'd2, r); check("ovr_status_busy", r, 32'h05);
      @(negedge clk);
      wait_idle();
      check("ovr_mosi", 32'(mosi_cap), 32'h12);
      bus_rd(2'd1, r); check("ovr_rx", r, 32'h12);
      bus_rd(2'd2, r); check("ovr_status_end", r, 32'h06);
      bus_wr(2'd2, 32'h1E);

      // abort after three rising SCLK edges
      edges = 0;
      bus_wr(2'd0, 32'hF0);
      for (int i = 0; i < 300 && edges < 3; i++) @(negedge clk);
      check("abt_edges", edges, 3);
      check("abt_sclk_hi", 32'(spi_sclk), 32'd1);
      spi_csn_in = 1'b1;
      @(negedge clk);
      check("abt_sclk_lo", 32'(spi_sclk), 32'd0);
      bus_rd(2'd2, r); check("abt_status", r, 32'h10);
      bus_rd(2'd1, r); check("abt_rx_kept", r, 32'h12);
      repeat (10) @(negedge clk);
      check("abt_no_edges", edges, 3);
      bus_wr(2'd2, 32'h10);
      spi_csn_in = 1'b0;

      // irq on completion, cleared by W1C of rx_valid
      bus_wr(2'd3, 32'h100);
      bus_wr(2'd0, 32'h81);
      check("irq_low_busy", 32'(irq), 32'd0);
      wait_idle();
      check("irq_set", 32'(irq), 32'd1);
      bus_rd(2'd1, r); check("irq_rx", r, 32'h81);
      bus_wr(2'd2, 32'h02);
      #1;
      check("irq_clr", 32'(irq), 32'd0);

      // asynchronous reset mid-transfer
      bus_wr(2'd3, 32'h005);
      edges = 0;
      bus_wr(2'd0, 32'hAA);
      for (int i = 0; i < 300 && !spi_sclk; i++) @(negedge clk);
      check("ar_sclk_hi", 32'(spi_sclk), 32'd1);
      address = 2'd2;
      #2;
      reset_n = 1'b0;
      #1;
      check("ar_sclk", 32'(spi_sclk), 32'd0);
      check("ar_status", readdata, 32'h0);
      address = 2'd3;
      #1;
      check("ar_control", readdata, 32'h3);
      @(negedge clk);
      reset_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
